// File: rtl/result_line_packer_if.sv
// Handshake bundle between the convolution result stream, the line packer and the
// result writer, plus the packer's line/word counters.
interface result_line_packer_if #(
   parameter int WORD_W         = 32,
   parameter int WORDS_PER_LINE = 16
);
   logic                               in_valid;
   logic [WORD_W-1:0]                  in_data;
   logic                               in_last;
   logic                               in_ready;
   logic                               out_valid;
   logic [WORD_W*WORDS_PER_LINE-1:0]   out_data;
   logic                               out_last;
   logic                               out_ready;
   logic [31:0]                        line_count;
   logic [31:0]                        word_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, line_count, word_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, line_count, word_count
   );
endinterface

// File: rtl/result_line_packer.sv
// Packs 32-bit convolution results into 512-bit cache lines with a two-deep line
// buffer (output register + accumulator); a partial final line is zero-padded.
module result_line_packer #(
   parameter int WORD_W         = 32,
   parameter int WORDS_PER_LINE = 16
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   clear,
   result_line_packer_if.slave    bus
);
   localparam int LINE_W = WORD_W * WORDS_PER_LINE;
   localparam int IDX_W  = $clog2(WORDS_PER_LINE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

   logic [LINE_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              acc_full_q, acc_full_d;
   logic              acc_last_q, acc_last_d;
   logic [LINE_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [31:0]       line_count_q, line_count_d;
   logic [31:0]       word_count_q, word_count_d;

   logic              out_free_s;
   logic              accept_s;
   logic              complete_s;
   logic              handoff_s;
   logic [LINE_W-1:0] acc_with_s;

   assign out_free_s = !out_valid_q || bus.out_ready;
   assign accept_s   = bus.in_valid && !acc_full_q;
   assign complete_s = accept_s && ((idx_q == LAST_IDX) || bus.in_last);
   assign handoff_s  = out_valid_q && bus.out_ready;

   // Current line including the incoming word; slots above idx are already zero.
   always_comb begin
      acc_with_s = acc_q;
      acc_with_s[idx_q*WORD_W +: WORD_W] = bus.in_data;
   end

   // Next-state logic for accumulator, output register and counters.
   always_comb begin
      acc_d        = acc_q;
      idx_d        = idx_q;
      acc_full_d   = acc_full_q;
      acc_last_d   = acc_last_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      line_count_d = line_count_q;
      word_count_d = word_count_q;

      if (handoff_s) begin
         out_valid_d  = 1'b0;
         line_count_d = line_count_q + 32'd1;
      end else begin
         line_count_d = line_count_q;
      end

      // A held line takes priority; input is stalled while the accumulator is full.
      if (acc_full_q && out_free_s) begin
         out_data_d  = acc_q;
         out_valid_d = 1'b1;
         out_last_d  = acc_last_q;
         acc_d       = '0;
         idx_d       = '0;
         acc_full_d  = 1'b0;
         acc_last_d  = 1'b0;
      end else if (accept_s) begin
         word_count_d = word_count_q + 32'd1;
         if (complete_s) begin
            if (out_free_s) begin
               out_data_d  = acc_with_s;
               out_valid_d = 1'b1;
               out_last_d  = bus.in_last;
               acc_d       = '0;
               idx_d       = '0;
            end else begin
               acc_d       = acc_with_s;
               idx_d       = '0;
               acc_full_d  = 1'b1;
               acc_last_d  = bus.in_last;
            end
         end else begin
            acc_d = acc_with_s;
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // State registers with synchronous reset and soft clear.
   always_ff @(posedge clk) begin
      if (!resetb || clear) begin
         acc_q        <= '0;
         idx_q        <= '0;
         acc_full_q   <= 1'b0;
         acc_last_q   <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         line_count_q <= 32'd0;
         word_count_q <= 32'd0;
      end else begin
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         acc_full_q   <= acc_full_d;
         acc_last_q   <= acc_last_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         line_count_q <= line_count_d;
         word_count_q <= word_count_d;
      end
   end

   assign bus.in_ready   = !acc_full_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_last   = out_last_q;
   assign bus.line_count = line_count_q;
   assign bus.word_count = word_count_q;
endmodule
